// File: rtl/input_buffer.sv
// input_buffer
//   Flit FIFO sitting at a router input port. The upstream output controller
//   writes flits and uses `full` as backpressure. The head flit is presented
//   first-word-fall-through to local routing/arbitration. A data value of zero
//   is the idle encoding and is never stored.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears pointers, count, overflow)
//   write     upstream write strobe (qualified by Data_in != 0 and !full)
//   Data_in   upstream flit, 0 = no flit
//   read      local consumer pops the head flit (ignored when empty)
//   Data_out  head flit, forced to 0 when empty
//   full      count == DEPTH
//   empty     count == 0
//   count     occupancy 0..DEPTH
//   overflow  one-cycle pulse per flit dropped because the FIFO was full
module input_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2   // log2(DEPTH); DEPTH must be a power of two >= 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one extra bit so they wrap modulo 2*DEPTH; only the low
  // ADDR_WIDTH bits address the array.
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0] count_q,  count_d;
  logic                overflow_q, overflow_d;

  logic flit_vld, wr_en, rd_en;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign overflow = overflow_q;

  // Stale memory contents survive reset; the empty forcing keeps them hidden.
  assign Data_out = empty ? '0 : mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

  always_comb begin
    flit_vld = (Data_in != '0);
    // full is not bypassed by a same-cycle read, and an empty FIFO never
    // forwards a same-cycle write to the reader.
    wr_en    = write && flit_vld && !full;
    rd_en    = read && !empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + ONE;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase

    overflow_d = write && flit_vld && full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= Data_in;
  end

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer (DEPTH=4, DATA_WIDTH=8). A scoreboard
// queue holds flits expected on Data_out in order; a small occupancy model
// provides expected count/full/empty/overflow.
module tb_input_buffer;
  localparam int DW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] Data_in = '0;
  logic          read = 1'b0;
  logic [DW-1:0] Data_out;
  logic          full, empty, overflow;
  logic [2:0]    count;

  input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .Data_in(Data_in), .read(read),
    .Data_out(Data_out), .full(full), .empty(empty), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sb[$];
  int            mcount = 0;
  logic          exp_ovf = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  function automatic logic [DW-1:0] exp_head();
    return (sb.size() > 0) ? sb[0] : '0;
  endfunction

  // Drive one cycle of stimulus, update the model, then sample #1 after the edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    bit aw, ar;
    write = w; Data_in = d; read = r;
    aw = w && (d != 0) && (mcount < DEPTH);
    ar = r && (mcount > 0);
    exp_ovf = w && (d != 0) && (mcount == DEPTH);
    if (ar) void'(sb.pop_front());
    if (aw) sb.push_back(d);
    mcount = mcount + int'(aw) - int'(ar);
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0; Data_in = '0;
  endtask

  task automatic model_reset();
    sb.delete(); mcount = 0; exp_ovf = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 8'h12, 1'b0);
    step(1'b1, 8'h34, 1'b0);
    step(1'b1, 8'h56, 1'b0);
    step(1'b1, 8'h78, 1'b0);
    step(1'b1, 8'h9a, 1'b0);   // leaves overflow high going into reset
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_checks++; if (Data_out !== 8'h00) $display("FAIL reset_dout got %h exp 00", Data_out); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h00, 1'b0);
      n_checks++; if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0)
        $display("FAIL idle_zero got count=%0d empty=%b ovf=%b exp 0/1/0", count, empty, overflow);
      else n_pass++;
    end
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] pat[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pat[i], 1'b0);
      n_checks++; if (count !== 3'(i + 1)) $display("FAIL fill_count got %0d exp %0d", count, i + 1); else n_pass++;
    end
    n_checks++; if (full !== 1'b1) $display("FAIL fill_full got %b exp 1", full); else n_pass++;
    n_checks++; if (Data_out !== 8'h11) $display("FAIL fill_head got %h exp 11", Data_out); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (Data_out !== exp_head()) $display("FAIL drain_data got %h exp %h", Data_out, exp_head()); else n_pass++;
      step(1'b0, 8'h00, 1'b1);
      n_checks++; if (full !== 1'b0) $display("FAIL drain_full got %b exp 0", full); else n_pass++;
    end
    n_checks++; if (Data_out !== 8'h00 || empty !== 1'b1)
      $display("FAIL drain_empty got dout=%h empty=%b exp 00/1", Data_out, empty);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] pat[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0);
    step(1'b1, 8'h55, 1'b0);
    n_checks++; if (overflow !== 1'b1 || count !== 3'd4)
      $display("FAIL ovf_pulse got ovf=%b count=%0d exp 1/4", overflow, count);
    else n_pass++;
    step(1'b0, 8'h00, 1'b0);
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else n_pass++;
    step(1'b1, 8'h5a, 1'b0);
    step(1'b1, 8'h5b, 1'b0);
    n_checks++; if (overflow !== exp_ovf || overflow !== 1'b1)
      $display("FAIL ovf_b2b got %b exp 1", overflow);
    else n_pass++;
    while (mcount > 0) begin
      n_checks++; if (Data_out !== exp_head()) $display("FAIL ovf_drain got %h exp %h", Data_out, exp_head()); else n_pass++;
      step(1'b0, 8'h00, 1'b1);
    end
    n_checks++; if (empty !== 1'b1 || overflow !== 1'b0)
      $display("FAIL ovf_end got empty=%b ovf=%b exp 1/0", empty, overflow);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h66, 1'b1);
    n_checks++; if (count !== 3'd2 || Data_out !== 8'h22)
      $display("FAIL sim_mid got count=%0d dout=%h exp 2/22", count, Data_out);
    else n_pass++;
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    n_checks++; if (full !== 1'b1) $display("FAIL sim_full got %b exp 1", full); else n_pass++;
    step(1'b1, 8'h77, 1'b1);
    n_checks++; if (count !== 3'd3 || overflow !== 1'b1 || Data_out !== 8'h66)
      $display("FAIL sim_atfull got count=%0d ovf=%b dout=%h exp 3/1/66", count, overflow, Data_out);
    else n_pass++;
    while (mcount > 0) begin
      n_checks++; if (Data_out !== exp_head()) $display("FAIL sim_drain got %h exp %h", Data_out, exp_head()); else n_pass++;
      step(1'b0, 8'h00, 1'b1);
    end
    step(1'b1, 8'h88, 1'b1);
    n_checks++; if (count !== 3'd1 || Data_out !== 8'h88)
      $display("FAIL sim_atempty got count=%0d dout=%h exp 1/88", count, Data_out);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_wrap();
    logic [DW-1:0] nxt = 8'h01;
    logic [DW-1:0] got[$];
    int            errs = 0;
    while (nxt <= 8'h0a || mcount > 0) begin
      if (nxt <= 8'h0a && mcount < 3) begin
        step(1'b1, nxt, 1'b0);
        nxt++;
      end else begin
        got.push_back(Data_out);
        if (Data_out !== exp_head()) errs++;
        step(1'b0, 8'h00, 1'b1);
      end
      if (full !== (mcount == DEPTH) || empty !== (mcount == 0) || count !== mcount[2:0]) errs++;
    end
    n_checks++; if (errs != 0) $display("FAIL wrap_flags got %0d errors exp 0", errs); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== 8'(i + 1))
        $display("FAIL wrap_order idx %0d got %h exp %h", i, (i < got.size()) ? got[i] : 8'hxx, 8'(i + 1));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'ha1, 1'b0);
    step(1'b1, 8'ha2, 1'b0);
    step(1'b1, 8'ha3, 1'b0);
    n_checks++; if (count !== 3'd3) $display("FAIL rmid_pre got %0d exp 3", count); else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (count !== 3'd0 || empty !== 1'b1 || Data_out !== 8'h00)
      $display("FAIL rmid_clear got count=%0d empty=%b dout=%h exp 0/1/00", count, empty, Data_out);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 8'h99, 1'b0);
    n_checks++; if (Data_out !== 8'h99 || count !== 3'd1)
      $display("FAIL rmid_write got dout=%h count=%0d exp 99/1", Data_out, count);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1);
    n_checks++; if (empty !== 1'b1) $display("FAIL rmid_end got %b exp 1", empty); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    pulse_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/input_buffer.md
# input_buffer

Flit FIFO at each router input port, directly downstream of the upstream router's output controller. Captures flits on `write`, returns `full` as backpressure (the upstream controller gates `write` with it), and presents the head flit first-word-fall-through to the local routing and arbitration logic. A data value of zero is the idle/no-flit encoding and is never stored.

## Interface
- DATA_WIDTH, 8, flit width in bits
- DEPTH, 4, number of entries; power of two, at least 2
- ADDR_WIDTH, 2, log2(DEPTH); must be consistent with DEPTH
- clk  input  1  the only clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low; clears all state immediately
- write  input  1  upstream write strobe
- Data_in  input  DATA_WIDTH  upstream flit; 0 means no flit
- read  input  1  local consumer pops the head flit
- Data_out  output  DATA_WIDTH  head flit; 0 when empty
- full  output  1  count == DEPTH; returned upstream as backpressure
- empty  output  1  count == 0
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse: a write was dropped because the FIFO was full

## Operation
- Storage: DEPTH x DATA_WIDTH circular array. Write and read pointers are ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits index the array. Pointers wrap modulo 2*DEPTH.
- count is a registered counter; full and empty decode combinationally from count.
- Write is accepted iff write=1, Data_in != 0 and full=0 (full as sampled in the current cycle). The flit is stored at wr_ptr and wr_ptr increments.
- write=1 with Data_in=0: no-op, no flag.
- write=1, Data_in != 0 and full=1: the flit is dropped, no state changes, and overflow=1 for the following cycle.
- Read is accepted iff read=1 and empty=0. rd_ptr increments. read while empty is ignored with no flag.
- Both accepted in the same cycle: both pointers advance and count is unchanged.
- Full and both strobes: read accepted, write dropped, overflow pulses. Full status is not bypassed by a same-cycle read.
- Empty and both strobes: write accepted, read ignored. There is no write-to-read bypass.
- Data_out = mem[rd_ptr] when empty=0, else 0 (forced combinationally).
- count update: +1 on accepted write only, -1 on accepted read only, otherwise unchanged.
- No state machine beyond the pointer/count registers. The overflow register is the only additional flop.

## Timing
- Reset (asynchronous assert, synchronous release at next edge):
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0
  - hence full=0, empty=1, Data_out=0
  - Memory contents are not cleared; the empty forcing hides them.
- Reset asserted mid-operation discards all stored flits immediately.
- Write latency: a flit accepted at edge N is visible on Data_out with empty=0 in the cycle after edge N.
- Read: the consumer samples Data_out with read=1. After the edge, the next flit (or 0 if now empty) appears.
- full rises in the cycle after the DEPTH-th accepted write and falls in the cycle after the first accepted read.
- overflow is high for exactly one cycle per dropped flit. Back-to-back drops keep it high.
- Sustained simultaneous read and write at count k (0 < k < DEPTH) gives throughput of 1 flit/cycle with count held at k.

## Test plan
- Reset then idle:
  - Assert rst_n=0 mid-cycle -> full=0, empty=1, count=0, Data_out=0, overflow=0 immediately.
  - Data_in=0 with write=1 for 3 cycles -> count stays 0.
- Fill and drain (DEPTH=4):
  - Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count 1..4, full=1 after the 4th edge, Data_out=0x11.
  - Read 4 times -> Data_out 0x22, 0x33, 0x44, then 0 with empty=1.
- Overflow:
  - When full, write 0x55 -> overflow=1 for one cycle, count stays 4.
  - Drain -> 0x11..0x44 only; 0x55 never appears.
- Simultaneous access:
  - At count=2, write 0x66 and read for 1 cycle -> count=2, head advances.
  - At full, write 0x77 and read -> count=3, overflow pulses, 0x77 not stored.
  - At empty, write 0x88 and read -> count=1, Data_out=0x88.
- Wrap-around: perform 10 write/read pairs of 0x01..0x0A with occupancy cycling 0..3 -> output order is exactly 0x01..0x0A and full/empty are correct across the pointer wrap.
- Reset mid-operation: with count=3, pulse rst_n low -> count=0, empty=1 at once. A subsequent write of 0x99 reads back as 0x99.
